// File: rtl/button_pkg.sv
// Shared types and helpers for the button code-entry block.
package button_pkg;

    typedef enum logic {
        ENTRY = 1'b0,
        FULL  = 1'b1
    } state_e;

    // Ceiling log2 for sizing fields from parameters; never returns less than 1.
    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        for (int i = 0; i < 32; i++) begin
            if (x > 0) begin
                r++;
                x = x >>> 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button channel: 2-flop synchronizer followed by a consecutive-sample
// debouncer that flips its stable level after DEB_CYC disagreeing samples.
module btn_debounce
    import button_pkg::*;
#(
    parameter int DEB_CYC = 20
) (
    input  logic clk_1k,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_db
);

    localparam int DC_W = clog2(DEB_CYC);
    localparam logic [DC_W-1:0] CNT_LAST = DC_W'(DEB_CYC - 1);

    logic            s1_q;
    logic            s2_q;
    logic            stable_q;
    logic [DC_W-1:0] cnt_q;

    always_ff @(posedge clk_1k) begin
        if (rst) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            s1_q <= btn_raw;
            s2_q <= s1_q;
            // Any sample that agrees with the stable level restarts the count.
            if (s2_q == stable_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                stable_q <= ~stable_q;
                cnt_q    <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign btn_db = stable_q;

endmodule

// File: rtl/button_entry.sv
// Debounced one-hot keypad front end collecting a CODE_LEN-digit pickup code,
// with multi-key rejection, overflow flagging and synchronous clear.
module button_entry
    import button_pkg::*;
#(
    parameter  int N_BTN    = 8,
    parameter  int DEB_CYC  = 20,
    parameter  int CODE_LEN = 4,
    localparam int DIG_W    = clog2(N_BTN),
    localparam int CNT_W    = clog2(CODE_LEN + 1)
) (
    input  logic                      clk_1k,
    input  logic                      rst,
    input  logic [N_BTN-1:0]          btn_p,
    input  logic                      clr,
    output logic [DIG_W-1:0]          num_in,
    output logic [N_BTN-1:0]          led,
    output logic                      plus,
    output logic [CODE_LEN*DIG_W-1:0] code_buf,
    output logic [CNT_W-1:0]          digit_cnt,
    output logic                      code_valid,
    output logic                      multi_err,
    output logic                      ovf
);

    localparam logic [N_BTN-1:0] VEC_ONE  = N_BTN'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CODE_LEN - 1);

    logic [N_BTN-1:0] deb_vec;

    for (genvar g = 0; g < N_BTN; g++) begin : g_deb
        btn_debounce #(
            .DEB_CYC (DEB_CYC)
        ) u_deb (
            .clk_1k  (clk_1k),
            .rst     (rst),
            .btn_raw (btn_p[g]),
            .btn_db  (deb_vec[g])
        );
    end

    state_e                    state_q;
    logic [N_BTN-1:0]          prev_q;
    logic [N_BTN-1:0]          led_q;
    logic [DIG_W-1:0]          num_q;
    logic [CODE_LEN*DIG_W-1:0] code_q;
    logic [CNT_W-1:0]          cnt_q;
    logic                      valid_q;
    logic                      plus_q;
    logic                      merr_q;
    logic                      ovf_q;

    logic             now_onehot;
    logic             now_multi;
    logic             prev_zero;
    logic             prev_onehot;
    logic             evt_press;
    logic             evt_multi;
    logic [DIG_W-1:0] evt_idx;
    logic [N_BTN-1:0] led_d;

    // A press needs a clean all-released history, so after a multi-key
    // rejection nothing is accepted until every key is released again.
    always_comb begin
        now_onehot  = (deb_vec != '0) && ((deb_vec & (deb_vec - VEC_ONE)) == '0);
        now_multi   = (deb_vec != '0) && !now_onehot;
        prev_zero   = (prev_q == '0);
        prev_onehot = (prev_q != '0) && ((prev_q & (prev_q - VEC_ONE)) == '0);
        evt_press   = prev_zero && now_onehot;
        evt_multi   = (prev_zero || prev_onehot) && now_multi;
        evt_idx     = '0;
        for (int i = 0; i < N_BTN; i++) begin
            if (deb_vec[i]) begin
                evt_idx = DIG_W'(i);
            end
        end
        led_d = now_onehot ? deb_vec : '0;
    end

    always_ff @(posedge clk_1k) begin
        if (rst) begin
            state_q <= ENTRY;
            prev_q  <= '0;
            led_q   <= '0;
            num_q   <= '0;
            code_q  <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            plus_q  <= 1'b0;
            merr_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            prev_q <= deb_vec;
            led_q  <= led_d;
            merr_q <= evt_multi;
            plus_q <= 1'b0;
            ovf_q  <= 1'b0;
            if (clr) begin
                // Clear takes priority over any press seen this cycle.
                state_q <= ENTRY;
                code_q  <= '0;
                cnt_q   <= '0;
                valid_q <= 1'b0;
            end else begin
                case (state_q)
                    ENTRY: begin
                        if (evt_press) begin
                            num_q <= evt_idx;
                            code_q[int'(cnt_q)*DIG_W +: DIG_W] <= evt_idx;
                            cnt_q  <= cnt_q + 1'b1;
                            plus_q <= 1'b1;
                            if (cnt_q == CNT_LAST) begin
                                state_q <= FULL;
                                valid_q <= 1'b1;
                            end
                        end
                    end
                    FULL: begin
                        if (evt_press) begin
                            ovf_q <= 1'b1;
                        end
                    end
                    default: state_q <= ENTRY;
                endcase
            end
        end
    end

    assign num_in     = num_q;
    assign led        = led_q;
    assign plus       = plus_q;
    assign code_buf   = code_q;
    assign digit_cnt  = cnt_q;
    assign code_valid = valid_q;
    assign multi_err  = merr_q;
    assign ovf        = ovf_q;

endmodule

// File: tb/tb_button_entry.sv
// Directed bench for button_entry with N_BTN=8, DEB_CYC=4, CODE_LEN=4.
module tb_button_entry;

    logic        clk_1k = 1'b0;
    logic        rst;
    logic        clr;
    logic [7:0]  btn_p;
    logic [2:0]  num_in;
    logic [7:0]  led;
    logic        plus;
    logic [11:0] code_buf;
    logic [2:0]  digit_cnt;
    logic        code_valid;
    logic        multi_err;
    logic        ovf;

    button_entry #(
        .N_BTN    (8),
        .DEB_CYC  (4),
        .CODE_LEN (4)
    ) dut (
        .clk_1k     (clk_1k),
        .rst        (rst),
        .btn_p      (btn_p),
        .clr        (clr),
        .num_in     (num_in),
        .led        (led),
        .plus       (plus),
        .code_buf   (code_buf),
        .digit_cnt  (digit_cnt),
        .code_valid (code_valid),
        .multi_err  (multi_err),
        .ovf        (ovf)
    );

    always #5 clk_1k = ~clk_1k;

    int errors = 0;
    int checks = 0;
    int k;
    int npl;
    int first_pl;
    int nmerr;
    int novf;
    logic [7:0] led_snap;
    int digs [4] = '{2, 7, 0, 5};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tally_reset();
        k = 0; npl = 0; first_pl = -1; nmerr = 0; novf = 0;
    endtask

    // Advance one clock and sample outputs 1 time unit after the edge.
    task automatic step();
        @(posedge clk_1k);
        #1;
        k++;
        if (plus) begin
            npl++;
            if (first_pl < 0) first_pl = k;
        end
        if (multi_err) nmerr++;
        if (ovf) novf++;
    endtask

    task automatic press_seq(input logic [7:0] v, input int hold);
        tally_reset();
        btn_p = v;
        for (int i = 0; i < hold; i++) begin
            step();
            if (k == 10) led_snap = led;
        end
        btn_p = 8'h00;
        repeat (10) step();
    endtask

    task automatic do_clr();
        clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; clr = 1'b0; btn_p = 8'h00; led_snap = 8'h00;
        tally_reset();
        repeat (3) @(posedge clk_1k);
        #1;
        chk("reset_outputs", {2'b0, num_in, led, plus, code_buf, digit_cnt, code_valid, multi_err, ovf}, 32'h0);
        rst = 1'b0;
        repeat (7) step();

        press_seq(8'h08, 20);
        chk("key3_plus_count", npl, 1);
        chk("key3_plus_latency", first_pl, 7);
        chk("key3_num_in", num_in, 3);
        chk("key3_digit_cnt", digit_cnt, 1);
        chk("key3_led_held", led_snap, 8'h08);
        chk("key3_led_released", led, 8'h00);

        do_clr();
        chk("clr1_digit_cnt", digit_cnt, 0);

        for (int i = 0; i < 4; i++) begin
            press_seq(8'h01 << digs[i], 12);
            chk("seq_plus_count", npl, 1);
        end
        chk("seq_code_buf", code_buf, 12'hA3A);
        chk("seq_code_valid", code_valid, 1);
        chk("seq_digit_cnt", digit_cnt, 4);
        chk("seq_num_in", num_in, 5);

        press_seq(8'h02, 12);
        chk("full_ovf_count", novf, 1);
        chk("full_plus_count", npl, 0);
        chk("full_code_buf", code_buf, 12'hA3A);
        chk("full_num_in", num_in, 5);
        chk("full_digit_cnt", digit_cnt, 4);

        do_clr();
        chk("clr2_code_buf", code_buf, 0);
        chk("clr2_digit_cnt", digit_cnt, 0);
        chk("clr2_code_valid", code_valid, 0);
        chk("clr2_num_in", num_in, 5);

        tally_reset();
        repeat (4) begin
            btn_p = 8'h01; step(); step();
            btn_p = 8'h00; step();
        end
        chk("glitch_plus_count", npl, 0);

        press_seq(8'h11, 14);
        chk("multi_err_count", nmerr, 1);
        chk("multi_plus_count", npl, 0);
        chk("multi_led", led_snap, 8'h00);

        // Clear lands on the same edge that would register a press.
        tally_reset();
        btn_p = 8'h02;
        repeat (6) step();
        clr = 1'b1;
        step();
        chk("clrpress_plus", plus, 0);
        clr = 1'b0;
        repeat (6) step();
        btn_p = 8'h00;
        repeat (10) step();
        chk("clrpress_plus_count", npl, 0);
        chk("clrpress_ovf_count", novf, 0);
        chk("clrpress_digit_cnt", digit_cnt, 0);

        tally_reset();
        btn_p = 8'h04;
        repeat (9) step();
        chk("pre_rst_plus_count", npl, 1);
        rst = 1'b1;
        step();
        chk("rst_outputs", {2'b0, num_in, led, plus, code_buf, digit_cnt, code_valid, multi_err, ovf}, 32'h0);
        rst = 1'b0;
        tally_reset();
        repeat (12) step();
        chk("post_rst_plus_count", npl, 1);
        chk("post_rst_latency", first_pl, 7);
        chk("post_rst_num_in", num_in, 2);
        chk("post_rst_digit_cnt", digit_cnt, 1);
        chk("post_rst_led", led, 8'h04);
        btn_p = 8'h00;
        repeat (10) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
